// File: rtl/simon_autoplayer_if.sv
// simon_autoplayer_if: game-facing signals of the Simon autoplayer.
// The master drives LEDs and enable; the slave answers with buttons.
interface simon_autoplayer_if;
  logic        enable;
  logic [3:0]  led;
  logic [15:0] ticks_per_milli;
  logic [3:0]  btn;
  logic        busy;
  logic        overflow;

  modport master (
    output enable,
    output led,
    output ticks_per_milli,
    input  btn,
    input  busy,
    input  overflow
  );

  modport slave (
    input  enable,
    input  led,
    input  ticks_per_milli,
    output btn,
    output busy,
    output overflow
  );
endinterface

// File: rtl/simon_autoplayer.sv
// simon_autoplayer: records the step sequence shown on a Simon game's
// LEDs and replays it on the buttons once the LEDs go quiet.
module simon_autoplayer #(
  parameter int DEPTH     = 32,
  parameter int MIN_ON_MS = 20,
  parameter int IDLE_MS   = 300,
  parameter int PRESS_MS  = 200,
  parameter int GAP_MS    = 100
) (
  input  logic              clk,
  input  logic              rst,
  simon_autoplayer_if.slave bus
);
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW   = $clog2(MIN_ON_MS + 1);
  localparam int QW   = $clog2(IDLE_MS + 1);
  localparam int TMAX = (PRESS_MS > GAP_MS) ? PRESS_MS : GAP_MS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [LW-1:0] LEN_FULL   = LW'(DEPTH);
  localparam logic [OW-1:0] ON_MAX     = OW'(MIN_ON_MS);
  localparam logic [OW-1:0] ON_LAST    = OW'(MIN_ON_MS - 1);
  localparam logic [QW-1:0] Q_LAST     = QW'(IDLE_MS - 1);
  localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_MS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LISTEN,
    PRESS,
    RELEASE
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   len, len_n;
  logic [LW-1:0]   idx, idx_n;
  logic [OW-1:0]   on_cnt, on_n;
  logic [QW-1:0]   quiet_cnt, quiet_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic            ovf_q, ovf_n;
  logic            busy_q, busy_n;
  logic [3:0]      btn_q, btn_n;
  logic            wr_en;
  logic [3:0]      prev_led;
  logic [1:0]      seq [DEPTH];
  logic [1:0]      seq_rd;

  logic [15:0]     pre_cnt;
  logic            ms_tick;
  logic [3:0]      led_m1;
  logic            led_onehot;
  logic [1:0]      led_code;

  assign ms_tick = (bus.ticks_per_milli <= 16'd1) ||
                   (pre_cnt == bus.ticks_per_milli - 16'd1);

  assign led_m1     = bus.led - 4'd1;
  assign led_onehot = (bus.led != 4'd0) &&
                      ((bus.led & led_m1) == 4'd0);
  assign led_code   = {bus.led[3] | bus.led[2],
                       bus.led[3] | bus.led[1]};

  assign bus.btn      = btn_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

  // free-running millisecond prescaler
  always_ff @(posedge clk) begin
    if (rst || ms_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 16'd1;
  end

  // last cycle's LEDs, to tell a steady LED from a fresh one
  always_ff @(posedge clk) begin
    if (rst) prev_led <= '0;
    else     prev_led <= bus.led;
  end

  // step buffer; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (!rst && wr_en) seq[len[IW-1:0]] <= led_code;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      on_cnt    <= '0;
      quiet_cnt <= '0;
      tmr       <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      btn_q     <= '0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      idx       <= idx_n;
      on_cnt    <= on_n;
      quiet_cnt <= quiet_n;
      tmr       <= tmr_n;
      ovf_q     <= ovf_n;
      busy_q    <= busy_n;
      btn_q     <= btn_n;
    end
  end

  // next state: record while listening, replay once quiet
  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    on_n    = on_cnt;
    quiet_n = quiet_cnt;
    tmr_n   = tmr;
    ovf_n   = ovf_q;
    wr_en   = 1'b0;
    seq_rd  = '0;
    busy_n  = 1'b0;
    btn_n   = '0;

    unique case (state)
      IDLE: begin
        len_n = '0;
        if (bus.enable) begin
          state_n = LISTEN;
          on_n    = '0;
          quiet_n = '0;
        end
      end

      LISTEN: begin
        if (bus.led == 4'd0) begin
          on_n = '0;
          if (len != '0 && ms_tick) begin
            if (quiet_cnt == Q_LAST) begin
              state_n = PRESS;
              idx_n   = '0;
              tmr_n   = '0;
              quiet_n = '0;
            end else begin
              quiet_n = quiet_cnt + QW'(1);
            end
          end
        end else begin
          quiet_n = '0;
          if (!led_onehot || bus.led != prev_led) begin
            on_n = '0;
          end else if (ms_tick && on_cnt != ON_MAX) begin
            on_n = on_cnt + OW'(1);
            if (on_cnt == ON_LAST) begin
              if (len == LEN_FULL) begin
                ovf_n = 1'b1;
              end else begin
                wr_en = 1'b1;
                len_n = len + LW'(1);
              end
            end
          end
        end
      end

      PRESS: begin
        if (ms_tick) begin
          if (tmr == PRESS_LAST) begin
            state_n = RELEASE;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
      end

      RELEASE: begin
        if (ms_tick) begin
          if (tmr == GAP_LAST) begin
            tmr_n = '0;
            idx_n = idx + LW'(1);
            if (idx_n == len) begin
              state_n = LISTEN;
              len_n   = '0;
              on_n    = '0;
              quiet_n = '0;
            end else begin
              state_n = PRESS;
            end
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase

    if (!bus.enable) begin
      state_n = IDLE;
      len_n   = '0;
      idx_n   = '0;
      on_n    = '0;
      quiet_n = '0;
      tmr_n   = '0;
      wr_en   = 1'b0;
    end

    seq_rd = seq[idx_n[IW-1:0]];
    busy_n = (state_n == PRESS) || (state_n == RELEASE);
    btn_n  = (state_n == PRESS) ? (4'd1 << seq_rd) : 4'd0;
  end
endmodule
